// File: rtl/fetch_stage.sv
// fetch_stage: variable-length (1/2 word) fetch into IF/ID; ports clk, rst, stall, branch_taken/target in; imem_* bus; ifid_* out
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_cs,
  output logic        imem_read,
  output logic        imem_write,
  input  logic [15:0] imem_data,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_imm,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_next_pc
);
  typedef enum logic {FETCH_OP, FETCH_IMM} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_op_pc;
  logic [15:0] r_op_hold;
  logic [31:0] w_pc_inc;
  assign w_pc_inc   = r_pc + 32'd1;
  assign imem_addr  = r_pc;
  assign imem_cs    = ~rst;
  assign imem_read  = ~rst;
  assign imem_write = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_state      <= FETCH_OP;
      r_op_hold    <= '0;
      r_op_pc      <= '0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_imm     <= '0;
      ifid_pc      <= '0;
      ifid_next_pc <= '0;
    end else if (branch_taken) begin
      r_pc       <= branch_target;
      r_state    <= FETCH_OP;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_pc_inc;
      if (r_state == FETCH_IMM) begin
        ifid_instr   <= r_op_hold;
        ifid_imm     <= imem_data;
        ifid_pc      <= r_op_pc;
        ifid_next_pc <= w_pc_inc;
        ifid_valid   <= 1'b1;
        r_state      <= FETCH_OP;
      end else if (imem_data[15]) begin
        r_op_hold  <= imem_data;
        r_op_pc    <= r_pc;
        ifid_valid <= 1'b0;
        r_state    <= FETCH_IMM;
      end else begin
        ifid_instr   <= imem_data;
        ifid_imm     <= '0;
        ifid_pc      <= r_pc;
        ifid_next_pc <= w_pc_inc;
        ifid_valid   <= 1'b1;
      end
    end
  end
endmodule
